sync_burst_sram: RTL and testbench

Parametrised synchronous burst SRAM behavioural model, the clocked successor of the team's asynchronous 32-bit SRAM model. It sits on the external-memory side of the UVM verification environment as the memory behind the SRAM controller under test. It adds configurable data width and depth, a pipelined read latency, an internal burst address counter with linear or interleaved wrap, and per-byte active-low write enables. Memory contents are never reset; all control state is.

---
 rtl/sync_burst_sram.sv | 120 ++++++++++++
 tb/tb_sync_burst_sram.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_burst_sram.sv
// sync_burst_sram: clocked burst SRAM model with pipelined reads, an internal
// burst counter (linear or interleaved wrap) and active-low byte enables.
// Memory contents survive reset; only the burst and read-pipeline control state is cleared.
module sync_burst_sram #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 21,
    parameter int READ_LAT   = 2,
    parameter int BURST_LEN  = 4,
    parameter int BURST_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    inout  wire  [DATA_W-1:0]   data,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] bsel_n,
    input  logic                cs_n,
    input  logic                wr_n,
    input  logic                adv_n,
    input  logic                oe_n
);
    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BURST_LEN);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} burst_state_t;

    burst_state_t      state, state_next;
    logic [ADDR_W-1:0] base, base_next;
    logic [LB-1:0]     beat, beat_next;

    logic              beat_valid;
    logic              beat_write;
    logic [ADDR_W-1:0] beat_base;
    logic [LB-1:0]     beat_idx;
    logic [LB-1:0]     low_addr;
    logic [ADDR_W-1:0] eff_addr;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [READ_LAT-1:0] pipe_valid;
    logic [DATA_W-1:0]   pipe_word [READ_LAT];

    // Decide whether this edge issues a beat (new access or burst advance) and the next burst state
    always_comb begin
        state_next = state;
        base_next  = base;
        beat_next  = beat;
        beat_valid = 1'b0;
        beat_write = 1'b0;
        beat_base  = base;
        beat_idx   = beat;
        if (!cs_n) begin
            state_next = wr_n ? ST_READ : ST_WRITE;
            base_next  = addr;
            beat_next  = '0;
            beat_valid = 1'b1;
            beat_write = !wr_n;
            beat_base  = addr;
            beat_idx   = '0;
        end else if (!adv_n && state != ST_IDLE) begin
            beat_next  = beat + 1'b1;
            beat_valid = 1'b1;
            beat_write = (state == ST_WRITE);
            beat_idx   = beat_next;
        end
    end

    // Effective beat address: the low bits wrap inside the aligned burst block, never crossing it
    always_comb begin
        if (BURST_MODE == 0) begin
            low_addr = beat_base[LB-1:0] + beat_idx;
        end else begin
            low_addr = beat_base[LB-1:0] ^ beat_idx;
        end
        eff_addr = {beat_base[ADDR_W-1:LB], low_addr};
    end

    // Burst control registers; an idle burst state means adv_n pulses are ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            base  <= '0;
            beat  <= '0;
        end else begin
            state <= state_next;
            base  <= base_next;
            beat  <= beat_next;
        end
    end

    // Byte-masked array write; beats presented while in reset are dropped, contents are never cleared
    always_ff @(posedge clk) begin
        if (rst_n && beat_valid && beat_write) begin
            for (int i = 0; i < BYTES; i++) begin
                if (!bsel_n[i]) begin
                    mem[eff_addr][8*i +: 8] <= data[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline: one beat per edge, so a read never collides with a same-edge write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= beat_valid && !beat_write;
            for (int s = 1; s < READ_LAT; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
            end
        end
        pipe_word[0] <= mem[eff_addr];
        for (int s = 1; s < READ_LAT; s++) begin
            pipe_word[s] <= pipe_word[s-1];
        end
    end

    // oe_n gates the driver combinationally; a word reaching the last stage with oe_n high is lost
    assign data = (pipe_valid[READ_LAT-1] && !oe_n) ? pipe_word[READ_LAT-1] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sync_burst_sram.sv
// Testbench for sync_burst_sram: four instances (READ_LAT 1..4, alternating
// linear/interleaved wrap) share one stimulus stream and are compared every
// cycle against a behavioural memory/burst model, with table rows and reset sequences.
module tb_sync_burst_sram;
    localparam int NDUT  = 4;
    localparam int BL    = 4;
    localparam int AW    = 12;
    localparam int SLOTS = 16;

    logic          clk = 1'b0;
    logic          rst_n, cs_n, wr_n, adv_n, oe_n;
    logic [AW-1:0] addr;
    logic [3:0]    bsel_n;
    logic          tb_drv;
    logic [31:0]   tb_wdata;
    wire  [31:0]   d0, d1, d2, d3;
    logic [NDUT-1:0] drv;
    logic [31:0]   val [NDUT];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] ref_mem  [2][4096];
    logic        exp_vld  [NDUT][SLOTS];
    logic [31:0] exp_word [NDUT][SLOTS];
    bit          m_act, m_wr;
    int          m_base, m_beat;

    typedef struct {
        logic        cs_n, wr_n, adv_n, oe_n;
        logic [3:0]  bsel_n;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        e0_drv;
        logic [31:0] e0_data;
        logic        e1_drv;
        logic [31:0] e1_data;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    assign d0 = tb_drv ? tb_wdata : 32'bz;
    assign d1 = tb_drv ? tb_wdata : 32'bz;
    assign d2 = tb_drv ? tb_wdata : 32'bz;
    assign d3 = tb_drv ? tb_wdata : 32'bz;
    assign drv[0] = !(d0 === 32'bz);
    assign drv[1] = !(d1 === 32'bz);
    assign drv[2] = !(d2 === 32'bz);
    assign drv[3] = !(d3 === 32'bz);
    assign val[0] = d0;
    assign val[1] = d1;
    assign val[2] = d2;
    assign val[3] = d3;

    sync_burst_sram #(.DATA_W(32), .ADDR_W(AW), .READ_LAT(1), .BURST_LEN(BL), .BURST_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data(d0), .addr(addr), .bsel_n(bsel_n),
        .cs_n(cs_n), .wr_n(wr_n), .adv_n(adv_n), .oe_n(oe_n));
    sync_burst_sram #(.DATA_W(32), .ADDR_W(AW), .READ_LAT(2), .BURST_LEN(BL), .BURST_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data(d1), .addr(addr), .bsel_n(bsel_n),
        .cs_n(cs_n), .wr_n(wr_n), .adv_n(adv_n), .oe_n(oe_n));
    sync_burst_sram #(.DATA_W(32), .ADDR_W(AW), .READ_LAT(3), .BURST_LEN(BL), .BURST_MODE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data(d2), .addr(addr), .bsel_n(bsel_n),
        .cs_n(cs_n), .wr_n(wr_n), .adv_n(adv_n), .oe_n(oe_n));
    sync_burst_sram #(.DATA_W(32), .ADDR_W(AW), .READ_LAT(4), .BURST_LEN(BL), .BURST_MODE(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .data(d3), .addr(addr), .bsel_n(bsel_n),
        .cs_n(cs_n), .wr_n(wr_n), .adv_n(adv_n), .oe_n(oe_n));

    // Beat address from the burst rules: offset within the aligned block, added modulo or XORed
    function automatic int eff_of(input int mode, input int b, input int bt);
        int blk;
        blk = b - (b % BL);
        if (mode == 0) return blk + ((b % BL) + bt) % BL;
        return b ^ bt;
    endfunction

    // Reference model step for one clock edge; instance k has latency k+1 and mode k%2
    task automatic modelEdge(input bit r, input bit c, input bit w, input bit a,
                             input logic [3:0] b, input int ad, input logic [31:0] wd);
        bit issue;
        int ea;
        issue = 1'b0;
        if (!r) begin
            m_act  = 1'b0;
            m_beat = 0;
            for (int k = 0; k < NDUT; k++)
                for (int s = 0; s < SLOTS; s++) exp_vld[k][s] = 1'b0;
            return;
        end
        if (!c) begin
            m_act  = 1'b1;
            m_wr   = !w;
            m_base = ad;
            m_beat = 0;
            issue  = 1'b1;
        end else if (!a && m_act) begin
            m_beat = (m_beat + 1) % BL;
            issue  = 1'b1;
        end
        if (issue) begin
            if (m_wr) begin
                for (int m = 0; m < 2; m++) begin
                    ea = eff_of(m, m_base, m_beat);
                    for (int i = 0; i < 4; i++)
                        if (!b[i]) ref_mem[m][ea][8*i +: 8] = wd[8*i +: 8];
                end
            end else begin
                for (int k = 0; k < NDUT; k++) begin
                    ea = eff_of(k % 2, m_base, m_beat);
                    exp_vld[k][(cyc + k) % SLOTS]  = 1'b1;
                    exp_word[k][(cyc + k) % SLOTS] = ref_mem[k % 2][ea];
                end
            end
        end
    endtask

    // Compare one instance's bus against the model for the current cycle
    task automatic checkOutput(input int k);
        int   s;
        logic e_d;
        s   = cyc % SLOTS;
        e_d = exp_vld[k][s] && !oe_n;
        if (tb_drv) return;
        tests++;
        if (drv[k] !== e_d) begin
            fails++;
            $display("[TB] FAIL drive dut%0d cyc %0d: got %0b, want %0b", k, cyc, drv[k], e_d);
        end else if (e_d) begin
            tests++;
            if (val[k] !== exp_word[k][s]) begin
                fails++;
                $display("[TB] FAIL data dut%0d cyc %0d: got %h, want %h", k, cyc, val[k], exp_word[k][s]);
            end
        end
    endtask

    // Compare one instance's bus against a hand-written expectation
    task automatic checkRow(input string name, input int k, input logic e_d, input logic [31:0] e_v);
        if (tb_drv) return;
        tests++;
        if (drv[k] !== e_d || (e_d && val[k] !== e_v)) begin
            fails++;
            $display("[TB] FAIL %s dut%0d: got drv=%0b data=%h, want drv=%0b data=%h",
                     name, k, drv[k], val[k], e_d, e_v);
        end
    endtask

    // Drive one cycle at the falling edge, step the model at the rising edge, check 1ns later
    task automatic applyStimulus(input bit r, input bit c, input bit w, input bit a, input bit o,
                                 input logic [3:0] b, input logic [11:0] ad, input logic [31:0] wd);
        @(negedge clk);
        rst_n    = r;
        cs_n     = c;
        wr_n     = w;
        adv_n    = a;
        oe_n     = o;
        bsel_n   = b;
        addr     = ad;
        tb_wdata = wd;
        tb_drv   = r && ((!c && !w) || (c && !a && m_act && m_wr));
        @(posedge clk);
        cyc++;
        modelEdge(r, c, w, a, b, int'(ad), wd);
        #1;
        for (int k = 0; k < NDUT; k++) checkOutput(k);
        for (int k = 0; k < NDUT; k++) exp_vld[k][cyc % SLOTS] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; adv_n = 1'b1; oe_n = 1'b1;
        bsel_n = 4'hF; addr = '0; tb_wdata = '0; tb_drv = 1'b0;
        m_act = 1'b0; m_wr = 1'b0; m_base = 0; m_beat = 0;
        for (int k = 0; k < NDUT; k++)
            for (int s = 0; s < SLOTS; s++) begin
                exp_vld[k][s]  = 1'b0;
                exp_word[k][s] = '0;
            end

        // initial reset, then preload a known window so every later read has defined contents
        applyStimulus(0, 1, 1, 1, 0, 4'hF, 12'h000, 32'h0);
        applyStimulus(0, 1, 1, 1, 0, 4'hF, 12'h000, 32'h0);
        for (int a = 0; a < 'h500; a++)
            applyStimulus(1, 0, 0, 1, 1, 4'h0, 12'(a), 32'hC0DE_0000 | a);

        // table rows: byte enables, linear/interleaved bursts, abort into a new read
        tbl.push_back('{0, 0, 1, 1, 4'h0, 12'h100, 32'hAABBCCDD, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 4'hA, 12'h100, 32'h11223344, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 4'hF, 12'h100, 0, 1, 32'hAA22CC44, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 4'hF, 12'h000, 0, 0, 0, 1, 32'hAA22CC44});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{0, 0, 1, 1, 4'h0, 12'(12'h200 + i), 32'(i), 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 4'hF, 12'h206, 0, 1, 32'd6, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 4'hF, 12'h000, 0, 1, 32'd7, 1, 32'd6});
        tbl.push_back('{1, 1, 0, 0, 4'hF, 12'h000, 0, 1, 32'd4, 1, 32'd7});
        tbl.push_back('{1, 1, 0, 0, 4'hF, 12'h000, 0, 1, 32'd5, 1, 32'd4});
        tbl.push_back('{1, 1, 1, 0, 4'hF, 12'h000, 0, 0, 0, 1, 32'd5});
        tbl.push_back('{0, 1, 1, 0, 4'hF, 12'h205, 0, 1, 32'd5, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 4'hF, 12'h000, 0, 1, 32'd6, 1, 32'd5});
        tbl.push_back('{1, 1, 0, 0, 4'hF, 12'h000, 0, 1, 32'd7, 1, 32'd4});
        tbl.push_back('{1, 1, 0, 0, 4'hF, 12'h000, 0, 1, 32'd4, 1, 32'd7});
        tbl.push_back('{1, 1, 1, 0, 4'hF, 12'h000, 0, 0, 0, 1, 32'd6});
        tbl.push_back('{0, 1, 1, 0, 4'hF, 12'h300, 0, 1, 32'hC0DE0300, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 4'hF, 12'h000, 0, 1, 32'hC0DE0301, 1, 32'hC0DE0300});
        tbl.push_back('{0, 1, 1, 0, 4'hF, 12'h400, 0, 1, 32'hC0DE0400, 1, 32'hC0DE0301});
        tbl.push_back('{1, 1, 1, 0, 4'hF, 12'h000, 0, 0, 0, 1, 32'hC0DE0400});
        tbl.push_back('{1, 1, 1, 0, 4'hF, 12'h000, 0, 0, 0, 0, 0});
        foreach (tbl[i]) begin
            applyStimulus(1, tbl[i].cs_n, tbl[i].wr_n, tbl[i].adv_n, tbl[i].oe_n,
                          tbl[i].bsel_n, tbl[i].addr, tbl[i].wdata);
            checkRow($sformatf("row%0d", i), 0, tbl[i].e0_drv, tbl[i].e0_data);
            checkRow($sformatf("row%0d", i), 1, tbl[i].e1_drv, tbl[i].e1_data);
        end

        // reset with reads presented, stray advances with no burst, then exact read latency
        applyStimulus(0, 0, 1, 1, 0, 4'hF, 12'h010, 0);
        applyStimulus(0, 0, 1, 1, 0, 4'hF, 12'h010, 0);
        for (int k = 0; k < NDUT; k++) checkRow("reset_z", k, 0, 0);
        for (int j = 0; j < 2; j++) begin
            applyStimulus(1, 1, 1, 0, 0, 4'hF, 12'h000, 0);
            for (int k = 0; k < NDUT; k++) checkRow("adv_no_burst", k, 0, 0);
        end
        applyStimulus(1, 0, 1, 1, 0, 4'hF, 12'h010, 0);
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < NDUT; k++)
                checkRow($sformatf("latency_step%0d", j), k, logic'(j == k), 32'hC0DE0010);
            applyStimulus(1, 1, 1, 1, 0, 4'hF, 12'h000, 0);
        end

        // reset while reads are in flight, then memory contents are still there
        applyStimulus(1, 0, 1, 1, 0, 4'hF, 12'h010, 0);
        applyStimulus(1, 0, 1, 1, 0, 4'hF, 12'h011, 0);
        applyStimulus(0, 1, 1, 1, 0, 4'hF, 12'h000, 0);
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < NDUT; k++) checkRow("reset_flush", k, 0, 0);
            applyStimulus(1, 1, 1, 0, 0, 4'hF, 12'h000, 0);
        end
        applyStimulus(1, 0, 1, 1, 0, 4'hF, 12'h010, 0);
        checkRow("post_reset_read", 0, 1, 32'hC0DE0010);
        for (int j = 0; j < 4; j++) applyStimulus(1, 1, 1, 1, 0, 4'hF, 12'h000, 0);

        // randomized traffic; oe_n is kept high whenever a write beat is issued
        for (int i = 0; i < 3000; i++) begin
            bit          r, c, w, a, o;
            logic [3:0]  b;
            logic [11:0] ad;
            logic [31:0] wd;
            r  = ($urandom_range(0, 99) != 0);
            c  = ($urandom_range(0, 9) >= 3);
            w  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) >= 7);
            o  = 1'($urandom_range(0, 1));
            b  = 4'($urandom);
            ad = 12'($urandom_range(0, 'h4FF));
            wd = $urandom;
            if (!o) begin
                if (!c) w = 1'b1;
                else if (m_act && m_wr) a = 1'b1;
            end
            applyStimulus(r, c, w, a, o, b, ad, wd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
